lsu_ctrl: RTL and testbench

- Load/store controller directly upstream of the 64-bit data memory (256 x 64-bit doublewords, combinational read, synchronous write).
- Accepts one load/store request from the execute stage through a valid/ready handshake and translates it into memory accesses.
- Sub-doubleword stores use read-modify-write. Loads are extracted and sign/zero-extended, then returned to writeback through a valid/ready response.

---
 rtl/lsu_pkg.sv | 56 +++++
 rtl/lsu_lane.sv | 34 +++
 rtl/lsu_ctrl.sv | 158 +++++++++++++++
 tb/tb_lsu_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store controller: size encodings,
// controller states and the lane-width helpers used by merge and extract.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WRITE  = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  // Byte-enable pattern of a lane of the given size, anchored at byte 0.
  function automatic logic [7:0] byte_mask(size_e size);
    case (size)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // Offset bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(size_e size);
    case (size)
      SZ_B:    return 3'b000;
      SZ_H:    return 3'b001;
      SZ_W:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  // Index of the most significant bit of an extracted lane (its sign bit).
  function automatic logic [5:0] lane_msb(size_e size);
    case (size)
      SZ_B:    return 6'd7;
      SZ_H:    return 6'd15;
      SZ_W:    return 6'd31;
      default: return 6'd63;
    endcase
  endfunction

  // Widen a per-byte enable into a per-bit mask.
  function automatic logic [63:0] expand_bytes(logic [7:0] m);
    logic [63:0] bits;
    for (int i = 0; i < 8; i++) bits[i*8 +: 8] = {8{m[i]}};
    return bits;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane logic for one 64-bit doubleword: merges store data into
// the lane at offset/size, and extracts plus sign/zero-extends a load lane.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [63:0] din,
  input  logic [63:0] wdata,
  input  logic [2:0]  offset,
  input  size_e       size,
  input  logic        is_unsigned,
  output logic [63:0] merged,
  output logic [63:0] loaded
);

  logic [5:0]  shamt;
  logic [63:0] keep;
  logic [63:0] lane_m;
  logic [63:0] shifted;
  logic        sign;

  assign shamt = {offset, 3'b000};

  // Merge store bytes into the lane, and extract/extend the load lane.
  always_comb begin
    keep    = expand_bytes(byte_mask(size));
    lane_m  = keep << shamt;
    merged  = (din & ~lane_m) | ((wdata << shamt) & lane_m);
    shifted = din >> shamt;
    sign    = ~is_unsigned & shifted[lane_msb(size)];
    // A doubleword has keep all-ones, so it passes through unextended.
    loaded  = (shifted & keep) | ({64{sign}} & ~keep);
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller in front of a 256 x 64-bit data memory (combinational
// read, synchronous write). Sub-doubleword stores use read-modify-write.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned requests return
// resp_err=1 without touching memory; otherwise offsets are forced aligned.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_IDX_W = 8,
  parameter int DATA_W    = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [63:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [63:0]       mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e                 state_q, state_d;
  logic                   store_q;
  size_e                  size_q;
  logic                   uns_q;
  logic [MEM_IDX_W+2:0]   addr_q;
  logic [63:0]            wdata_q;
  logic [63:0]            rdata_q;
  logic [63:0]            resp_rdata_q;
  logic                   accept;
  logic                   misalign;
  logic [2:0]             offset;
  logic [63:0]            lane_din;
  logic [63:0]            merged;
  logic [63:0]            loaded;
  logic [63:0]            mem_idx;
  logic                   unused_addr_bits;

  // Address bits above the memory index are don't-care: the index wraps.
  assign unused_addr_bits = ^req_addr[63:MEM_IDX_W+3];

  assign accept  = req_valid && (state_q == S_IDLE);
  assign mem_idx = {{(64-MEM_IDX_W){1'b0}}, addr_q[MEM_IDX_W+2:3]};
  // Clearing sub-size bits is a no-op for aligned requests, so it is safe
  // in both builds; with the trap enabled misaligned ones never get here.
  assign offset  = addr_q[2:0] & ~align_mask(size_q);

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_q;
  assign misalign = (req_addr[2:0] & align_mask(size_e'(req_size))) != 3'b000;
  assign resp_err = err_q;

  // Error flag is captured at accept and held for the whole response.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    err_q <= 1'b0;
    else if (accept) err_q <= misalign;
  end
`else
  assign misalign = 1'b0;
  assign resp_err = 1'b0;
`endif

  // Load extraction reads memory directly in ACCESS; the merge uses rdata_q.
  assign lane_din = (state_q == S_ACCESS) ? mem_rdata : rdata_q;

  lsu_lane u_lane (
    .din         (lane_din),
    .wdata       (wdata_q),
    .offset      (offset),
    .size        (size_q),
    .is_unsigned (uns_q),
    .merged      (merged),
    .loaded      (loaded)
  );

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others regardless of block ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = misalign ? S_RESP : S_ACCESS;
      S_ACCESS: state_d = (store_q && size_q != SZ_D) ? S_WRITE : S_RESP;
      S_WRITE:  state_d = S_RESP;
      S_RESP:   if (resp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Request latch, read capture and response data.
  // NOTE: these datapath registers are reset too, so resp_rdata and the read
  // copy come out of reset as a defined 0 rather than X.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      store_q      <= 1'b0;
      size_q       <= SZ_B;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      resp_rdata_q <= '0;
    end else if (accept) begin
      store_q      <= req_store;
      size_q       <= size_e'(req_size);
      uns_q        <= req_unsigned;
      addr_q       <= req_addr[MEM_IDX_W+2:0];
      wdata_q      <= req_wdata;
      resp_rdata_q <= '0;
    end else if (state_q == S_ACCESS) begin
      rdata_q <= mem_rdata;
      if (!store_q) resp_rdata_q <= loaded;
    end
  end

  assign resp_rdata = resp_rdata_q;

  // Output decode from the current state.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    case (state_q)
      S_IDLE:   req_ready = 1'b1;
      S_ACCESS: begin
        mem_addr = mem_idx;
        if (store_q && size_q == SZ_D) begin
          mem_we    = 1'b1;
          mem_wdata = wdata_q;
        end
      end
      S_WRITE: begin
        mem_addr  = mem_idx;
        mem_we    = 1'b1;
        mem_wdata = merged;
      end
      S_RESP:   resp_valid = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a small behavioural data memory.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [63:0] mem_addr;
  logic        mem_we;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [63:0] mem [256];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_idx = '0;
  logic [63:0] pre_data = '0;

  int unsigned cyc = 0;
  int unsigned we_cnt = 0;
  int unsigned we_at = 0;
  logic [63:0] we_data = '0;
  logic [63:0] we_addr = '0;

  lsu_ctrl dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_store    (req_store),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clock = ~clock;

  assign mem_rdata = mem[mem_addr[7:0]];

  // Memory model plus write monitor (count, cycle, data, index of last write).
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (mem_we) begin
      mem[mem_addr[7:0]] <= mem_wdata;
      we_cnt  <= we_cnt + 1;
      we_at   <= cyc;
      we_data <= mem_wdata;
      we_addr <= mem_addr;
    end else if (pre_we) begin
      mem[pre_idx] <= pre_data;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [7:0] idx, input logic [63:0] data);
    pre_idx  = idx;
    pre_data = data;
    pre_we   = 1'b1;
    step();
    pre_we   = 1'b0;
  endtask

  // Present a request for one cycle; returns the accept cycle number.
  task automatic issue(input logic st, input logic [1:0] sz, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       output int unsigned acc);
    check("req_ready_idle", {63'd0, req_ready}, 64'd1);
    req_store    = st;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    acc          = cyc;
    step();
    req_valid    = 1'b0;
    req_addr     = 64'hFFFF_FFFF_FFFF_FFFF;
    req_wdata    = 64'hDEAD_DEAD_DEAD_DEAD;
  endtask

  // Latency in cycles from accept (cycle 0) to resp_valid, bounded.
  task automatic wait_resp(output int unsigned lat);
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 12) begin
      step();
      lat++;
    end
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [1:0] sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] exp);
    int unsigned acc, lat;
    issue(1'b0, sz, uns, addr, 64'd0, acc);
    wait_resp(lat);
    check({tag, "_lat"}, 64'(lat), 64'd2);
    check({tag, "_rdata"}, resp_rdata, exp);
    check({tag, "_err"}, {63'd0, resp_err}, 64'd0);
    consume();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
    check({tag, "_resp_valid"}, {63'd0, resp_valid}, 64'd0);
    check({tag, "_resp_err"}, {63'd0, resp_err}, 64'd0);
    check({tag, "_resp_rdata"}, resp_rdata, 64'd0);
    check({tag, "_mem_we"}, {63'd0, mem_we}, 64'd0);
    check({tag, "_mem_addr"}, mem_addr, 64'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 64'd0);
  endtask

  initial begin
    int unsigned acc, lat, w0;
    for (int i = 0; i < 256; i++) mem[i] = 64'd0;

    // Reset values, held in reset.
    #3;
    check_reset_outputs("rst");
    @(negedge clock);
    reset_n = 1'b1;
    step();

    preload(8'd1, 64'h8877_6655_4433_2211);

    // Signed byte load at the top byte of the doubleword.
    do_load("ld_b_s_0f", SZ_B, 1'b0, 64'h0F, 64'hFFFF_FFFF_FFFF_FF88);
    // Unsigned word load from the upper half.
    do_load("ld_w_u_0c", SZ_W, 1'b1, 64'h0C, 64'h0000_0000_8877_6655);
    // Signed byte load with a positive value.
    do_load("ld_b_s_08", SZ_B, 1'b0, 64'h08, 64'h0000_0000_0000_0011);

    // Half store: read-modify-write, single write pulse in WRITE (cycle 2).
    w0 = we_cnt;
    issue(1'b1, SZ_H, 1'b0, 64'h0A, 64'h1234_5678_9ABC_BEEF, acc);
    check("st_h_access_we", {63'd0, mem_we}, 64'd0);
    wait_resp(lat);
    check("st_h_lat", 64'(lat), 64'd3);
    check("st_h_we_cnt", 64'(we_cnt - w0), 64'd1);
    check("st_h_we_cycle", 64'(we_at - acc), 64'd2);
    check("st_h_wdata", we_data, 64'h8877_6655_BEEF_2211);
    check("st_h_widx", we_addr, 64'd1);
    check("st_h_rdata", resp_rdata, 64'd0);
    consume();

    // Half loads of the merged value, signed and unsigned.
    do_load("ld_h_s_0a", SZ_H, 1'b0, 64'h0A, 64'hFFFF_FFFF_FFFF_BEEF);
    do_load("ld_h_u_0a", SZ_H, 1'b1, 64'h0A, 64'h0000_0000_0000_BEEF);

    // Double store at 0x800 wraps to index 0, written in ACCESS only.
    w0 = we_cnt;
    issue(1'b1, SZ_D, 1'b0, 64'h800, 64'h0123_4567_89AB_CDEF, acc);
    check("st_d_access_we", {63'd0, mem_we}, 64'd1);
    check("st_d_access_addr", mem_addr, 64'd0);
    check("st_d_access_wdata", mem_wdata, 64'h0123_4567_89AB_CDEF);
    wait_resp(lat);
    check("st_d_lat", 64'(lat), 64'd2);
    check("st_d_we_cnt", 64'(we_cnt - w0), 64'd1);
    check("st_d_we_cycle", 64'(we_at - acc), 64'd1);
    consume();
    do_load("ld_d_000", SZ_D, 1'b0, 64'h000, 64'h0123_4567_89AB_CDEF);
    do_load("ld_d_800", SZ_D, 1'b1, 64'h800, 64'h0123_4567_89AB_CDEF);

    // Response held off for 5 cycles with a new request waiting.
    issue(1'b0, SZ_D, 1'b0, 64'h08, 64'd0, acc);
    wait_resp(lat);
    check("hold_lat", 64'(lat), 64'd2);
    w0 = we_cnt;
    req_valid = 1'b1;
    req_store = 1'b1;
    req_size  = SZ_D;
    req_addr  = 64'h20;
    req_wdata = 64'hCAFE_CAFE_CAFE_CAFE;
    for (int i = 0; i < 5; i++) begin
      check("hold_resp_valid", {63'd0, resp_valid}, 64'd1);
      check("hold_rdata", resp_rdata, 64'h8877_6655_BEEF_2211);
      check("hold_req_ready", {63'd0, req_ready}, 64'd0);
      check("hold_mem_addr", mem_addr, 64'd0);
      step();
    end
    check("hold_no_write", 64'(we_cnt - w0), 64'd0);
    req_valid = 1'b0;
    consume();
    check("hold_back_idle", {63'd0, req_ready}, 64'd1);
    check("hold_idx4_untouched", mem[4], 64'd0);

    // Misaligned word load at 0x06.
    w0 = we_cnt;
    issue(1'b0, SZ_W, 1'b0, 64'h06, 64'd0, acc);
    wait_resp(lat);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_lat", 64'(lat), 64'd1);
    check("mis_err", {63'd0, resp_err}, 64'd1);
    check("mis_rdata", resp_rdata, 64'd0);
`else
    // Forced to 0x04: upper word of index 0.
    check("mis_lat", 64'(lat), 64'd2);
    check("mis_err", {63'd0, resp_err}, 64'd0);
    check("mis_rdata", resp_rdata, 64'h0000_0000_0123_4567);
`endif
    check("mis_no_write", 64'(we_cnt - w0), 64'd0);
    consume();

    // Reset asserted during WRITE of a byte store.
    preload(8'd2, 64'hAAAA_AAAA_AAAA_AAAA);
    w0 = we_cnt;
    issue(1'b1, SZ_B, 1'b0, 64'h13, 64'h55, acc);
    check("rstw_access_we", {63'd0, mem_we}, 64'd0);
    step();
    check("rstw_write_we", {63'd0, mem_we}, 64'd1);
    check("rstw_write_addr", mem_addr, 64'd2);
    check("rstw_write_data", mem_wdata, 64'hAAAA_AAAA_55AA_AAAA);
    reset_n = 1'b0;
    #1;
    check("rstw_we_drop", {63'd0, mem_we}, 64'd0);
    step();
    check("rstw_no_write", 64'(we_cnt - w0), 64'd0);
    reset_n = 1'b1;
    #1;
    check_reset_outputs("rstw_post");
    step();
    do_load("rstw_mem", SZ_D, 1'b0, 64'h10, 64'hAAAA_AAAA_AAAA_AAAA);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
